// File: rtl/rr_arb_pkg.sv
// Shared round-robin arbitration types and the rotate/priority-encode helper.
// Reused by every arbiter in the narrow-data mux path.
package rr_arb_pkg;

    localparam int N_REQ = 4;

    typedef logic [1:0] req_idx_t;

    typedef struct packed {
        logic     found;
        req_idx_t idx;
    } pick_t;

    // Lowest set bit of vld at or after ptr, searching upward with wrap.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] vld, input req_idx_t ptr);
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        pick_t              res;
        dbl       = {vld, vld};
        rot       = dbl[ptr +: N_REQ];
        res.found = |rot;
        res.idx   = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                res.idx = ptr + req_idx_t'(k);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational 4-way round-robin pick: rotate by ptr, priority-encode, un-rotate.
// Outputs the granted index and whether any requester was valid.
module rr_pick_4
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] vld_i,
    input  req_idx_t         ptr_i,
    output logic             found_o,
    output req_idx_t         idx_o
);

    pick_t pick;

    always_comb begin
        pick    = rr_pick(vld_i, ptr_i);
        found_o = pick.found;
        idx_o   = pick.idx;
    end

endmodule

// File: rtl/rr_arb_mux_4.sv
// Round-robin 4:1 valid/ready arbiter with a single-entry registered output stage.
// Optional per-requester saturating grant counters when RR_ARB_GRANT_CNT_EN is defined.
module rr_arb_mux_4
    import rr_arb_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   in_vld,
    input  logic [N_REQ*W-1:0] in_data,
    output logic [N_REQ-1:0]   in_rdy,
    output logic               out_vld,
    output logic [W-1:0]       out_data,
    output logic [1:0]         out_sel,
    input  logic               out_rdy
`ifdef RR_ARB_GRANT_CNT_EN
    ,
    output logic [N_REQ*CNT_W-1:0] grant_cnt
`endif
);

    logic           out_vld_q, out_vld_d;
    logic [W-1:0]   out_data_q, out_data_d;
    req_idx_t       out_sel_q, out_sel_d;
    req_idx_t       ptr_q, ptr_d;
    logic           found;
    req_idx_t       grant_idx;
    logic           load;
    logic           xfer;

    rr_pick_4 u_pick (
        .vld_i   (in_vld),
        .ptr_i   (ptr_q),
        .found_o (found),
        .idx_o   (grant_idx)
    );

    // Gating with rst_n keeps in_rdy low while reset is held, even though load is 1 then.
    always_comb begin
        load       = ~out_vld_q | out_rdy;
        xfer       = load & found & rst_n;
        in_rdy     = '0;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_sel_d  = out_sel_q;
        ptr_d      = ptr_q;
        if (xfer) begin
            in_rdy     = N_REQ'(1) << grant_idx;
            out_vld_d  = 1'b1;
            out_data_d = in_data[grant_idx*W +: W];
            out_sel_d  = grant_idx;
            ptr_d      = grant_idx + 2'd1;
        end else if (load) begin
            out_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_sel_q  <= '0;
            ptr_q      <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_sel_q  <= out_sel_d;
            ptr_q      <= ptr_d;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_data = out_data_q;
    assign out_sel  = out_sel_q;

`ifdef RR_ARB_GRANT_CNT_EN
    logic [N_REQ-1:0][CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (in_rdy[i] && !(&cnt_q[i])) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign grant_cnt = cnt_q;
`else
    // Counter width still participates in parameter sanity when counters are compiled out.
    if (W < 1 || CNT_W < 1) begin : g_bad_param_width
    end
`endif

endmodule
